// File: rtl/arb_mux_2to1_if.sv
// Stream bundle around the 2:1 round-robin arbiter: producers A and B in, registered word y out.
// "master" is the environment side (producers and consumer); "slave" is the arbiter itself.
interface arb_mux_2to1_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             s;

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, s
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, s
  );
endinterface

// File: rtl/arb_mux_2to1.sv
// Two-input round-robin stream arbiter with a registered output stage.
// s is the select of the downstream 2:1 mux and names the source of the held word.
// Optional macro ARB_MUX_2TO1_FIXED_PRIO_EN: A always wins ties and no priority flop is built.
module arb_mux_2to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  arb_mux_2to1_if.slave  bus
);

  logic             prio;
  logic             grant_vld;
  logic             grant_b;
  logic             space;
  logic             load;

  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q,  y_data_d;
  logic             s_q,       s_d;

`ifdef ARB_MUX_2TO1_FIXED_PRIO_EN
  // Priority permanently on A.
  always_comb prio = 1'b0;
`else
  logic prio_q, prio_d;

  assign prio = prio_q;

  // Round-robin pointer: after each load, prefer the side that was not served.
  always_comb begin
    prio_d = prio_q;
    if (load) prio_d = ~grant_b;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`endif

  // Grant decision and load condition; ready never feeds back into a valid.
  always_comb begin
    grant_vld = bus.a_valid | bus.b_valid;
    grant_b   = bus.b_valid & (~bus.a_valid | prio);
    space     = ~y_valid_q | bus.y_ready;
    load      = space & grant_vld;
  end

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign bus.a_ready = rst_n & load & ~grant_b;
  assign bus.b_ready = rst_n & load &  grant_b;

  // Output register next state: load replaces, accept without load drains, otherwise hold.
  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    s_d       = s_q;
    if (load) begin
      y_valid_d = 1'b1;
      y_data_d  = grant_b ? bus.b_data : bus.a_data;
      s_d       = grant_b;
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // Output registers; reset drops the held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      s_q       <= 1'b0;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      s_q       <= s_d;
    end
  end

  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.s       = s_q;

endmodule

// File: tb/tb_arb_mux_2to1.sv
// Directed bench for arb_mux_2to1; expectations follow ARB_MUX_2TO1_FIXED_PRIO_EN when defined.
module tb_arb_mux_2to1;

`ifdef ARB_MUX_2TO1_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  arb_mux_2to1_if #(.WIDTH(8)) bus ();

  arb_mux_2to1 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Drive one cycle of inputs, check readies before the edge and registered outputs after it.
  task automatic step(input string tag,
                      input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd, input logic yr,
                      input logic e_ar, input logic e_br,
                      input logic e_yv, input logic [7:0] e_yd, input logic e_s);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.y_ready = yr;
    #1;
    check({tag, "_a_ready"}, 32'(bus.a_ready), 32'(e_ar));
    check({tag, "_b_ready"}, 32'(bus.b_ready), 32'(e_br));
    @(posedge clk);
    #1;
    check({tag, "_y_valid"}, 32'(bus.y_valid), 32'(e_yv));
    check({tag, "_y_data"},  32'(bus.y_data),  32'(e_yd));
    check({tag, "_s"},       32'(bus.s),       32'(e_s));
    @(negedge clk);
  endtask

  initial begin
    logic gb;
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_data  = 8'hEE;
    bus.b_valid = 1'b1;
    bus.b_data  = 8'hDD;
    bus.y_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Held in reset with both producers valid.
    check("rst_y_valid", 32'(bus.y_valid), 32'd0);
    check("rst_y_data",  32'(bus.y_data),  32'd0);
    check("rst_s",       32'(bus.s),       32'd0);
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("rst_b_ready", 32'(bus.b_ready), 32'd0);
    rst_n = 1'b1;

    // Fill the register, then reset asynchronously mid-stream.
    step("pre", 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h11;
    bus.y_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_y_valid", 32'(bus.y_valid), 32'd0);
    check("mid_rst_y_data",  32'(bus.y_data),  32'd0);
    check("mid_rst_s",       32'(bus.s),       32'd0);
    check("mid_rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("mid_rst_b_ready", 32'(bus.b_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First word after release appears one cycle after acceptance.
    step("first", 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    // B-only word moves the pointer back to A.
    step("b_only", 1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);

    // Both valid continuously: alternate A/B (or A only with fixed priority).
    for (int k = 0; k < 4; k++) begin
      gb = !FIXED && (k % 2 == 1);
      step($sformatf("alt%0d", k), 1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1,
           !gb, gb, 1'b1, gb ? 8'hB0 : 8'hA0, gb);
    end

    // Backpressure while FULL with 0x5A.
    step("bp_load", 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
    for (int k = 0; k < 3; k++)
      step($sformatf("bp_hold%0d", k), 1'b1, 8'h66, 1'b1, 8'h99, 1'b0,
           1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    // Release: accept and load in the same cycle, B preferred after A in round-robin.
    gb = !FIXED;
    step("bp_release", 1'b1, 8'h66, 1'b1, 8'h99, 1'b1,
         !gb, gb, 1'b1, gb ? 8'h99 : 8'h66, gb);

    // Single source B, four words back to back.
    for (int k = 1; k <= 4; k++)
      step($sformatf("b_seq%0d", k), 1'b0, 8'h00, 1'b1, 8'(k), 1'b1,
           1'b0, 1'b1, 1'b1, 8'(k), 1'b1);
    // Pointer now favours A.
    step("after_b", 1'b1, 8'hC1, 1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b0);

    // Drain: one A word, then idle; y_valid pulses once and data holds.
    step("drain_load", 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
    step("drain_idle0", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
    step("drain_idle1", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
